// File: rtl/test_status_monitor.sv
// End-of-test detector: snoops per-hart stores to TOHOST_ADDR and latches a sticky pass/fail/timeout verdict.
// Optional timeout watchdog is built only when TEST_MONITOR_TIMEOUT_EN is defined.
module test_status_monitor #(
  parameter int               N_CH           = 1,
  parameter int               ADDR_W         = 32,
  parameter int               DATA_W         = 32,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR   = 32'h0000_1000,
  parameter int               CNT_W          = 32,
  parameter int               TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                                   sys_clk,
  input  logic                                   sys_rst,
  input  logic                                   start,
  input  logic [N_CH-1:0]                        wr_en,
  input  logic [N_CH*ADDR_W-1:0]                 wr_addr,
  input  logic [N_CH*DATA_W-1:0]                 wr_data,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   pass,
  output logic                                   fail,
  output logic                                   timeout,
  output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] fail_ch,
  output logic [DATA_W-2:0]                      fail_code,
  output logic [N_CH-1:0]                        ch_passed,
  output logic [CNT_W-1:0]                       cycle_count
);

  localparam int FCH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  // start and wr_en are plain strobes sampled on the rising edge; there is no
  // backpressure, so every strobe seen in RUN is acted on in that same cycle.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_PASS    = 3'd2,
    S_FAIL    = 3'd3,
    S_TIMEOUT = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [N_CH-1:0]   hit_pass;
  logic [N_CH-1:0]   pass_mask_nxt;
  logic              hit_fail;
  logic [FCH_W-1:0]  fch_nxt;
  logic [DATA_W-2:0] fcode_nxt;
  logic              expired;
  logic [CNT_W-1:0]  cnt_inc;

  // Descending scan so the lowest failing channel is the last one written.
  always_comb begin
    hit_pass  = '0;
    hit_fail  = 1'b0;
    fch_nxt   = '0;
    fcode_nxt = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (wr_en[k] && (wr_addr[k*ADDR_W +: ADDR_W] == TOHOST_ADDR)) begin
        if (wr_data[k*DATA_W +: DATA_W] == DATA_W'(1)) begin
          hit_pass[k] = 1'b1;
        end else if (wr_data[k*DATA_W]) begin
          hit_fail  = 1'b1;
          fch_nxt   = FCH_W'(k);
          fcode_nxt = wr_data[k*DATA_W + 1 +: DATA_W - 1];
        end
      end
    end
  end

  assign pass_mask_nxt = ch_passed | hit_pass;
  assign cnt_inc       = (&cycle_count) ? cycle_count : cycle_count + CNT_W'(1);

`ifdef TEST_MONITOR_TIMEOUT_EN
  assign expired = (cycle_count >= CNT_W'(TIMEOUT_CYCLES));
`else
  assign expired = 1'b0;
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Result hits outrank the watchdog on the edge where it expires.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_RUN;
      S_RUN: begin
        if (hit_fail)            state_nxt = S_FAIL;
        else if (&pass_mask_nxt) state_nxt = S_PASS;
        else if (expired)        state_nxt = S_TIMEOUT;
      end
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cycle_count <= '0;
      ch_passed   <= '0;
      fail_ch     <= '0;
      fail_code   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cycle_count <= '0;
            ch_passed   <= '0;
          end
        end
        S_RUN: begin
          cycle_count <= cnt_inc;
          ch_passed   <= pass_mask_nxt;
          if (hit_fail) begin
            fail_ch   <= fch_nxt;
            fail_code <= fcode_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy    = (state == S_RUN);
    pass    = (state == S_PASS);
    fail    = (state == S_FAIL);
    timeout = (state == S_TIMEOUT);
    done    = pass | fail | timeout;
  end

endmodule

// File: doc/test_status_monitor.md
# test_status_monitor

Synthesizable end-of-test detector for the processor simulation and FPGA bring-up flow. Snoops N_CH data-memory write ports for stores to a fixed tohost address, decodes pass/fail codes (riscv-tests convention: 1 = pass, odd value > 1 = fail with code = value >> 1), counts run cycles, and raises a sticky verdict. Sits beside the data memory of each hart; the testbench or an FPGA LED/UART block consumes its outputs instead of polling memory by hierarchical path.

## Interface
- N_CH, 1, number of snooped write channels (harts), 1..8
- ADDR_W, 32, write address width
- DATA_W, 32, write data width (>= 2)
- TOHOST_ADDR, 32'h0000_1000, byte address that signals a test result
- CNT_W, 32, cycle counter width
- TIMEOUT_CYCLES, 1_000_000, run cycles before timeout verdict (< 2^CNT_W)
- sys_clk  in  1  clock; all logic on rising edge
- sys_rst  in  1  synchronous reset, active-high
- start  in  1  single-cycle pulse arming the monitor
- wr_en  in  N_CH  per-channel store strobe
- wr_addr  in  N_CH*ADDR_W  per-channel store address, channel k at [k*ADDR_W +: ADDR_W]
- wr_data  in  N_CH*DATA_W  per-channel store data, same packing
- busy  out  1  monitor in RUN
- done  out  1  verdict reached (sticky)
- pass  out  1  all channels reported 1
- fail  out  1  some channel reported a fail code
- timeout  out  1  TIMEOUT_CYCLES elapsed without verdict
- fail_ch  out  $clog2(N_CH) (min 1)  channel that failed
- fail_code  out  DATA_W-1  reported code (data >> 1)
- ch_passed  out  N_CH  per-channel pass mask
- cycle_count  out  CNT_W  cycles spent in RUN, saturating

## Operation
- States: IDLE, RUN, PASS, FAIL, TIMEOUT. Reset → IDLE; all outputs 0.
- IDLE: start → RUN, clears cycle_count and ch_passed. Writes ignored in IDLE.
- RUN: cycle_count increments each cycle, saturates at all-ones. Channel k hits when wr_en[k] and wr_addr == TOHOST_ADDR (full-width compare).
  - Hit, data == 1 → set ch_passed[k]. When ch_passed (including same-cycle hits) becomes all ones → PASS.
  - Hit, data[0] == 1 and data != 1 → FAIL; fail_code = data >> 1, fail_ch = k.
  - Hit with data[0] == 0 (incl. 0) → ignored (not a result write).
  - Multiple failing hits same cycle → lowest k wins. Fail beats pass in same cycle.
  - Repeated pass write on already-passed channel → no effect.
- PASS/FAIL/TIMEOUT terminal and sticky; start, writes ignored; cycle_count frozen. Only sys_rst leaves them.
- start in RUN ignored (no restart).
- done = PASS|FAIL|TIMEOUT; pass/fail/timeout one-hot when done, 0 otherwise.

## Timing
- Hit on cycle n (sampled at edge ending n) → verdict outputs valid from cycle n+1; one-cycle latency, registered outputs, no combinational path input→output.
- start sampled at edge t → busy = 1 from t+1; first RUN cycle has cycle_count = 0 and cycle_count = 1 after it.
- Timeout: if still in RUN when cycle_count reaches TIMEOUT_CYCLES, TIMEOUT entered on next edge; a result hit on the same edge takes priority over timeout.
- sys_rst asserted in any state, any cycle → next edge returns IDLE with all outputs 0, in-flight hits discarded.

## Configuration
- TEST_MONITOR_TIMEOUT_EN: defined → timeout comparator and TIMEOUT state present as above. Undefined → no timeout logic; timeout tied 0, RUN lasts until a result; cycle_count still counts/saturates.

## Test plan
- N_CH=1: start, 20 cycles, store 1 to 0x1000 → pass=1, done=1 next cycle, cycle_count=21, fail=0.
- N_CH=1: store 0x0000_0007 to 0x1000 → fail=1, fail_code=3, fail_ch=0; later store of 1 leaves fail=1, pass=0.
- N_CH=4: ch0,ch2 store 1, then ch1 stores 1 → ch_passed=4'b0111, busy=1; ch3 stores 1 → pass=1 next cycle. Same cycle ch1 writes 5, ch3 writes 9 → fail_ch=1, fail_code=2.
- Stores of 1 to 0x1004, store of 0 or 2 to 0x1000, and any store before start → no state change.
- With TEST_MONITOR_TIMEOUT_EN, TIMEOUT_CYCLES=50, no stores → timeout=1 after 51 RUN cycles; store of 1 on the expiry edge → pass instead. Without macro → timeout stays 0.
- sys_rst pulsed mid-RUN and in PASS → all outputs 0 next cycle; new start re-runs from cycle_count=0.
